fp_accumulator: RTL and testbench

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_lzc.sv | 17 +
 rtl/fp_accumulator.sv | 236 +++++++++++++++++++++++
 tb/tb_fp_accumulator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 constants, FSM state encoding and field view for the accumulator.
package fp_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;
  localparam logic [31:0] NEG_INF  = 32'hFF800000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4
  } fsm_state_e;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  function automatic logic [31:0] signed_inf(input logic sign);
    return sign ? NEG_INF : POS_INF;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero count of a 28-bit sum; an all-zero input reports 28.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [27:0] value_i,
  output logic [4:0]  count_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_o = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value_i[i]) count_o = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Multi-cycle binary32 accumulator: acc := acc + in_data through ALIGN/ADD/NORM/ROUND.
module fp_accumulator
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] in_data,
  output logic [31:0] result,
  output logic [31:0] acc,
  output logic        overflow,
  output logic        done,
  output logic        busy
);

  fsm_state_e  state_q, state_d;

  // frozen operands and architectural outputs
  logic [31:0] opa_q, opb_q;
  logic [31:0] acc_q, result_q;
  logic        overflow_q, done_q;

  // inter-stage datapath registers
  logic        spec_q, sign_q, sub_q, zsign_q, zero_q;
  logic [31:0] spec_val_q;
  logic [9:0]  exp_q;            // two's complement, may dip below 1 before flush
  logic [26:0] mb_q, ms_q;       // {hidden, frac[22:0], guard, round, sticky}
  logic [27:0] sum_q;
  logic [26:0] norm_q;

  // ALIGN stage combinational results
  fp32_t       a, b;
  logic        a_nan, a_inf, b_nan, b_inf;
  logic [23:0] ma, mb, big_m, small_m;
  logic [7:0]  ea, eb, big_e, small_e, diff;
  logic [26:0] small_ext, lost_mask;
  logic        spec_d, sign_d, sub_d, zsign_d;
  logic [31:0] spec_val_d;
  logic [9:0]  exp_align_d;
  logic [26:0] mb_d, ms_d;

  // ADD / NORM / ROUND combinational results
  logic [27:0] sum_d;
  logic [4:0]  lz_cnt, shamt;
  logic [26:0] shifted;
  logic [26:0] norm_d;
  logic [9:0]  exp_norm_d;
  logic        zero_d;
  logic        round_up;
  logic [24:0] mant_rnd;
  logic [22:0] frac_rnd;
  logic [9:0]  exp_rnd;
  logic [31:0] result_d;
  logic        overflow_d;

  fp_lzc u_lzc (
    .value_i (sum_q),
    .count_o (lz_cnt)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start only matters in IDLE, the rest is a fixed walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALIGN: classify operands, order by magnitude, shift the smaller with GRS
  always_comb begin
    a       = opa_q;
    b       = opb_q;
    a_nan   = (a.exp == EXP_MAX) && (a.frac != '0);
    a_inf   = (a.exp == EXP_MAX) && (a.frac == '0);
    b_nan   = (b.exp == EXP_MAX) && (b.frac != '0);
    b_inf   = (b.exp == EXP_MAX) && (b.frac == '0);
    // subnormals collapse to a zero significand but keep their sign
    ma      = (a.exp == 8'd0) ? 24'd0 : {1'b1, a.frac};
    ea      = (a.exp == 8'd0) ? 8'd0  : a.exp;
    mb      = (b.exp == 8'd0) ? 24'd0 : {1'b1, b.frac};
    eb      = (b.exp == 8'd0) ? 8'd0  : b.exp;
    big_e   = ea;
    big_m   = ma;
    small_e = eb;
    small_m = mb;
    sign_d  = a.sign;
    if ({eb, mb} > {ea, ma}) begin
      big_e   = eb;
      big_m   = mb;
      small_e = ea;
      small_m = ma;
      sign_d  = b.sign;
    end
    sub_d     = a.sign ^ b.sign;
    zsign_d   = a.sign & b.sign;     // only -0 + -0 keeps a negative zero
    diff      = big_e - small_e;
    small_ext = {small_m, 3'b000};
    lost_mask = '0;
    if (diff >= 8'd26) begin
      ms_d = {26'd0, |small_ext};
    end else begin
      lost_mask = (27'd1 << diff) - 27'd1;
      ms_d      = (small_ext >> diff) | {26'd0, |(small_ext & lost_mask)};
    end
    mb_d        = {big_m, 3'b000};
    exp_align_d = {2'b00, big_e};
    spec_d      = a_nan | b_nan | a_inf | b_inf;
    if (a_nan | b_nan | (a_inf & b_inf & sub_d)) spec_val_d = QNAN;
    else if (a_inf)                               spec_val_d = signed_inf(a.sign);
    else                                          spec_val_d = signed_inf(b.sign);
  end

  // ADD: larger magnitude is first, so the difference never goes negative
  always_comb begin
    sum_d = sub_q ? ({1'b0, mb_q} - {1'b0, ms_q}) : ({1'b0, mb_q} + {1'b0, ms_q});
  end

  // NORM: carry-out shifts right once, otherwise left by lz-1 to put the MSB at bit 26
  always_comb begin
    shamt   = lz_cnt - 5'd1;
    shifted = sum_q[26:0] << shamt;
    zero_d  = (sum_q == '0);
    if (sum_q[27]) begin
      norm_d     = sum_q[27:1] | {26'd0, sum_q[0]};
      exp_norm_d = exp_q + 10'd1;
    end else begin
      norm_d     = shifted;
      exp_norm_d = exp_q - {5'd0, shamt};
    end
  end

  // ROUND: nearest-even, renormalise on carry, then pick special/zero/inf/flush/normal
  always_comb begin
    round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    mant_rnd = {1'b0, norm_q[26:3]} + {24'd0, round_up};
    if (mant_rnd[24]) begin
      frac_rnd = mant_rnd[23:1];
      exp_rnd  = exp_q + 10'd1;
    end else begin
      frac_rnd = mant_rnd[22:0];
      exp_rnd  = exp_q;
    end
    overflow_d = 1'b0;
    if (spec_q) begin
      result_d = spec_val_q;
    end else if (zero_q) begin
      result_d = {zsign_q, 31'd0};
    end else if ($signed(exp_rnd) >= 10'sd255) begin
      result_d   = signed_inf(sign_q);
      overflow_d = 1'b1;
    end else if ($signed(exp_rnd) <= 10'sd0) begin
      result_d = {sign_q, 31'd0};
    end else begin
      result_d = {sign_q, exp_rnd[7:0], frac_rnd};
    end
  end

  // Datapath registers: each stage updates only its own slice of state
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      zsign_q    <= 1'b0;
      zero_q     <= 1'b0;
      exp_q      <= '0;
      mb_q       <= '0;
      ms_q       <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q <= clear ? 32'd0 : acc_q;
            opb_q <= in_data;
          end else if (clear) begin
            acc_q <= '0;
          end
        end
        ALIGN: begin
          spec_q     <= spec_d;
          spec_val_q <= spec_val_d;
          sign_q     <= sign_d;
          sub_q      <= sub_d;
          zsign_q    <= zsign_d;
          exp_q      <= exp_align_d;
          mb_q       <= mb_d;
          ms_q       <= ms_d;
        end
        ADD: begin
          sum_q <= sum_d;
        end
        NORM: begin
          norm_q <= norm_d;
          exp_q  <= exp_norm_d;
          zero_q <= zero_d;
        end
        ROUND: begin
          result_q   <= result_d;
          acc_q      <= result_d;
          overflow_q <= overflow_d;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign acc      = acc_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator; all stimulus changes and sampling on negedge.
module tb_fp_accumulator;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, clear;
  logic [31:0] in_data, result, acc;
  logic        overflow, done, busy;

  typedef struct packed { logic [31:0] res; logic ovf; } exp_t;
  typedef struct packed { logic clr; logic [31:0] data; logic [31:0] res; logic ovf; } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .in_data(in_data),
    .result(result), .acc(acc), .overflow(overflow), .done(done), .busy(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Drive a one-cycle start; called at a negedge, returns at the next negedge.
  task automatic issue(input logic c, input logic [31:0] d);
    start = 1'b1; clear = c; in_data = d;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
  endtask

  // Bounded wait for done; cyc counts negedges from the call.
  task automatic wait_done(output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      cyc = i;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({acc, result, overflow, done, busy} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: acc=%h result=%h ovf=%b done=%b busy=%b, expected all zero",
               acc, result, overflow, done, busy);
    end
    start = 1'b1; clear = 1'b1; in_data = 32'h3F800000;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || acc !== 32'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dominates: busy=%b acc=%h done=%b, expected 0/0/0", busy, acc, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_accumulate();
    vec_t v[4]; exp_t e; bit ok; int cyc;
    v = '{'{1'b1, 32'h41200000, 32'h41200000, 1'b0},
          '{1'b0, 32'h3F800000, 32'h41300000, 1'b0},
          '{1'b0, 32'h41200000, 32'h41A80000, 1'b0},
          '{1'b0, 32'hC1A80000, 32'h00000000, 1'b0}};
    foreach (v[i]) begin
      sb.push_back('{v[i].res, v[i].ovf});
      issue(v[i].clr, v[i].data);
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL accum_busy[%0d]: busy=%b, expected 1", i, busy); end
      wait_done(ok, cyc);
      e = sb.pop_front();
      n_chk++;
      if (!ok || cyc != 4) begin n_fail++; $display("FAIL accum_latency[%0d]: done after %0d cycles, expected 4", i, cyc); end
      n_chk++;
      if (result !== e.res || acc !== e.res || overflow !== e.ovf || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL accum_value[%0d]: result=%h acc=%h ovf=%b busy=%b, expected %h/%h/%b/0",
                 i, result, acc, overflow, busy, e.res, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[3]; exp_t e; bit ok; int cyc;
    v = '{'{1'b1, 32'h3F800000, 32'h3F800000, 1'b0},
          '{1'b0, 32'h3F800000, 32'h40000000, 1'b0},
          '{1'b0, 32'h3F800000, 32'h40400000, 1'b0}};
    foreach (v[i]) begin
      sb.push_back('{v[i].res, v[i].ovf});
      issue(v[i].clr, v[i].data);
      wait_done(ok, cyc);
      e = sb.pop_front();
      n_chk++;
      if (!ok || cyc != 4 || result !== e.res || acc !== e.res) begin
        n_fail++;
        $display("FAIL b2b[%0d]: ok=%0d cyc=%0d result=%h acc=%h, expected 4 cycles and %h", i, ok, cyc, result, acc, e.res);
      end
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_pulse: done=%b busy=%b one cycle after done, expected 0/0", done, busy);
    end
  endtask

  task automatic test_rounding();
    vec_t v[8]; exp_t e; bit ok; int cyc; logic [31:0] half_ulp;
    half_ulp = {1'b0, 8'(EXP_BIAS - 24), 23'd0};
    v = '{'{1'b1, 32'h3F800000, 32'h3F800000, 1'b0},
          '{1'b0, half_ulp,     32'h3F800000, 1'b0},
          '{1'b1, 32'h3F800001, 32'h3F800001, 1'b0},
          '{1'b0, half_ulp,     32'h3F800002, 1'b0},
          '{1'b1, 32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0},
          '{1'b0, half_ulp,     32'h40000000, 1'b0},
          '{1'b1, 32'h3F800000, 32'h3F800000, 1'b0},
          '{1'b0, 32'hB3800000, 32'h3F7FFFFF, 1'b0}};
    foreach (v[i]) begin
      sb.push_back('{v[i].res, v[i].ovf});
      issue(v[i].clr, v[i].data);
      wait_done(ok, cyc);
      e = sb.pop_front();
      n_chk++;
      if (!ok || result !== e.res || acc !== e.res || overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL round[%0d]: ok=%0d result=%h ovf=%b, expected %h/%b", i, ok, result, overflow, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_overflow_exc();
    vec_t v[9]; exp_t e; bit ok; int cyc;
    v = '{'{1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0},
          '{1'b0, 32'h7F7FFFFF, 32'h7F800000, 1'b1},
          '{1'b0, 32'hFF800000, 32'h7FC00000, 1'b0},
          '{1'b1, 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0},
          '{1'b0, 32'hFF7FFFFF, 32'hFF800000, 1'b1},
          '{1'b1, 32'h7F800000, 32'h7F800000, 1'b0},
          '{1'b0, 32'h40A00000, 32'h7F800000, 1'b0},
          '{1'b1, 32'h3F800000, 32'h3F800000, 1'b0},
          '{1'b0, 32'h7F800001, 32'h7FC00000, 1'b0}};
    foreach (v[i]) begin
      sb.push_back('{v[i].res, v[i].ovf});
      issue(v[i].clr, v[i].data);
      wait_done(ok, cyc);
      e = sb.pop_front();
      n_chk++;
      if (!ok || cyc != 4 || result !== e.res || acc !== e.res || overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL ovf_exc[%0d]: ok=%0d cyc=%0d result=%h ovf=%b, expected %h/%b in 4",
                 i, ok, cyc, result, overflow, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_cancel_subnormal();
    vec_t v[8]; exp_t e; bit ok; int cyc;
    v = '{'{1'b1, 32'h3F800000, 32'h3F800000, 1'b0},
          '{1'b0, 32'hBF800000, 32'h00000000, 1'b0},
          '{1'b1, 32'h00000001, 32'h00000000, 1'b0},
          '{1'b0, 32'h00000001, 32'h00000000, 1'b0},
          '{1'b1, 32'h80800001, 32'h80800001, 1'b0},
          '{1'b0, 32'h00800000, 32'h80000000, 1'b0},
          '{1'b0, 32'h80000000, 32'h80000000, 1'b0},
          '{1'b0, 32'h00000000, 32'h00000000, 1'b0}};
    foreach (v[i]) begin
      sb.push_back('{v[i].res, v[i].ovf});
      issue(v[i].clr, v[i].data);
      wait_done(ok, cyc);
      e = sb.pop_front();
      n_chk++;
      if (!ok || result !== e.res || acc !== e.res || overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL cancel_sub[%0d]: ok=%0d result=%h ovf=%b, expected %h/%b", i, ok, result, overflow, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_idle_clear();
    exp_t e; bit ok; int cyc;
    sb.push_back('{32'h40000000, 1'b0});
    issue(1'b1, 32'h40000000);
    wait_done(ok, cyc);
    e = sb.pop_front();
    n_chk++;
    if (!ok || acc !== e.res) begin n_fail++; $display("FAIL clr_load: acc=%h, expected %h", acc, e.res); end
    // clear alone while busy must not disturb the running sum
    sb.push_back('{32'h40400000, 1'b0});
    issue(1'b0, 32'h3F800000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_done(ok, cyc);
    e = sb.pop_front();
    n_chk++;
    if (!ok || result !== e.res || acc !== e.res) begin
      n_fail++;
      $display("FAIL clr_busy_ignored: result=%h acc=%h, expected %h", result, acc, e.res);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_chk++;
    if (acc !== 32'd0 || result !== 32'h40400000 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_idle: acc=%h result=%h done=%b busy=%b, expected 0/40400000/0/0", acc, result, done, busy);
    end
    sb.push_back('{32'h3F800000, 1'b0});
    issue(1'b0, 32'h3F800000);
    wait_done(ok, cyc);
    e = sb.pop_front();
    n_chk++;
    if (!ok || result !== e.res) begin n_fail++; $display("FAIL clr_after: result=%h, expected %h", result, e.res); end
  endtask

  task automatic test_busy_ignore();
    exp_t e; bit ok; int cyc; int n_done; logic [31:0] first_res;
    sb.push_back('{32'h3F800000, 1'b0});
    issue(1'b1, 32'h3F800000);
    wait_done(ok, cyc);
    e = sb.pop_front();
    n_chk++;
    if (!ok || acc !== e.res) begin n_fail++; $display("FAIL busy_load: acc=%h, expected %h", acc, e.res); end
    sb.push_back('{32'h40000000, 1'b0});
    issue(1'b0, 32'h3F800000);
    start = 1'b1; in_data = 32'h40800000;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; first_res = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (n_done == 0) first_res = result;
        n_done++;
      end
    end
    e = sb.pop_front();
    n_chk++;
    if (n_done != 1) begin n_fail++; $display("FAIL busy_done_count: %0d done pulses, expected 1", n_done); end
    n_chk++;
    if (first_res !== e.res || acc !== e.res) begin
      n_fail++;
      $display("FAIL busy_result: result=%h acc=%h, expected %h", first_res, acc, e.res);
    end
  endtask

  task automatic test_reset_abort();
    bit ok; int cyc; int n_done;
    issue(1'b1, 32'h40000000);
    wait_done(ok, cyc);
    n_chk++;
    if (!ok || acc !== 32'h40000000) begin n_fail++; $display("FAIL abort_load: acc=%h, expected 40000000", acc); end
    issue(1'b0, 32'h3F800000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || acc !== 32'd0 || result !== 32'd0 || overflow !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b acc=%h result=%h ovf=%b done=%b, expected all zero",
               busy, acc, result, overflow, done);
    end
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_chk++;
    if (n_done != 0 || acc !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d done pulses acc=%h, expected 0 and 00000000", n_done, acc);
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_back_to_back();
    test_rounding();
    test_overflow_exc();
    test_cancel_subnormal();
    test_idle_clear();
    test_busy_ignore();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
